pipeline_run_ctrl: RTL
======================

# pipeline_run_ctrl

Run/step sequencer for the five-stage MIPS pipeline. It generates the stage enable that feeds every pipeline register, including the execute stage's `i_enable`. It also gates PC and IF/ID for load-use stalls, drains in-flight instructions after a HALT reaches decode, and keeps a saturating count of executed cycles for the debug unit. Commands arrive from the debug/UART front end over a valid/ready handshake.

## Interface
- `CNT_BITS`, default 32: width of the cycle counter.
- `DRAIN_CYCLES`, default 3: cycles needed to retire EX/MEM/WB after HALT is decoded. Legal range is 1..15.
- Reset: `i_reset` is synchronous and active-high, on clock `i_clk`.
- `i_clk`, input, 1 bit: clock.
- `i_reset`, input, 1 bit: synchronous reset, active-high.
- `i_cmd_valid`, input, 1 bit: command present.
- `i_cmd`, input, 2 bits: 00 RUN, 01 STEP, 10 STOP, 11 CLEAR.
- `o_cmd_ready`, output, 1 bit: command accepted on the edge where valid & ready.
- `i_halt`, input, 1 bit: HALT opcode decoded in ID this cycle.
- `i_stall`, input, 1 bit: load-use hazard request from the hazard unit.
- `o_pipe_enable`, output, 1 bit: enable to all stage registers.
- `o_pc_enable`, output, 1 bit: PC update enable.
- `o_ifid_enable`, output, 1 bit: IF/ID register enable.
- `o_idex_bubble`, output, 1 bit: zero the ID/EX control signals this cycle.
- `o_pipe_clear`, output, 1 bit: one-cycle pulse that resets PC and the pipeline registers.
- `o_busy`, output, 1 bit: state is RUN, STEP or DRAIN.
- `o_done`, output, 1 bit: program finished (DONE state).
- `o_cycle_count`, output, `CNT_BITS` bits: count of cycles with `o_pipe_enable` = 1.

## Operation
- **States:** IDLE, RUN, STEP, DRAIN, DONE.
- **Command acceptance:** `o_cmd_ready` = 1 in IDLE, RUN and DONE; 0 in STEP and DRAIN.
- **IDLE**
  - RUN goes to RUN; STEP goes to STEP.
  - STOP is accepted as a no-op.
  - CLEAR stays in IDLE, pulses `o_pipe_clear` and zeroes the counter.
- **RUN**
  - `o_pipe_enable` = 1 every cycle.
  - STOP goes to IDLE (paused, resumable).
  - CLEAR goes to IDLE with a clear pulse and counter zeroed.
  - RUN and STEP are accepted as no-ops.
  - `i_halt` = 1 goes to DRAIN. It has priority over any command in the same cycle; that command is still accepted and then dropped.
- **STEP:** exactly one cycle with `o_pipe_enable` = 1, then IDLE. If `i_halt` = 1 in that cycle, go to DRAIN instead.
- **DRAIN**
  - Signal values: `o_pipe_enable` = 1, `o_pc_enable` = 0, `o_ifid_enable` = 0, `o_idex_bubble` = 1.
  - Down-counter loads `DRAIN_CYCLES`-1 on entry. When it reaches 0 in a DRAIN cycle, the next state is DONE.
  - DRAIN lasts exactly `DRAIN_CYCLES` cycles.
  - `i_stall` and `i_halt` are ignored.
- **DONE**
  - `o_done` = 1 and `o_pipe_enable` = 0.
  - Only CLEAR leaves: it goes to IDLE with a clear pulse and counter zeroed.
  - RUN, STEP and STOP are accepted as no-ops.
- **Stall (RUN/STEP only):** when `i_stall` = 1:
  - `o_pc_enable` = 0, `o_ifid_enable` = 0, `o_idex_bubble` = 1.
  - `o_pipe_enable` stays 1, and the cycle is counted.
  - A STEP that lands on a stall cycle consumes the step.
- **Outside stall:**
  - `o_pc_enable` and `o_ifid_enable` equal `o_pipe_enable`.
  - `o_idex_bubble` = 0.
- **Counter:** +1 on each cycle with `o_pipe_enable` = 1. It saturates at all-ones and does not wrap.
  - CLEAR zeroes it on the acceptance edge.
  - If CLEAR is accepted in RUN, the acceptance cycle still counts, and the counter reads 0 afterward.

## Timing
- State and counter are registered. Enables, bubble, busy and done are combinational decodes of state plus `i_stall`.
- A command accepted at edge N changes the state at edge N. The new enables are visible in cycle N+1, so latency is 1 cycle.
- `o_pipe_clear` is registered: high for the one cycle after the CLEAR acceptance edge.
- HALT sampled at edge N gives DRAIN during cycles N+1 .. N+`DRAIN_CYCLES`, with `o_done` high from cycle N+`DRAIN_CYCLES`+1.
- Reset values:
  - state IDLE, counter 0, drain counter 0.
  - `o_pipe_clear` 0, `o_pipe_enable` 0, `o_pc_enable` 0, `o_ifid_enable` 0, `o_idex_bubble` 0.
  - `o_busy` 0, `o_done` 0.
  - `o_cmd_ready` 1 (IDLE).
- Reset mid-RUN or mid-DRAIN returns to IDLE on that edge. Any pending command is dropped.

## Structure
- Package `pipeline_ctrl_pkg` holds the state enum, the four command codes and the `DRAIN_CYCLES` default.
- Sub-module `sat_counter` (width parameter; inputs clear and inc; output count) implements `o_cycle_count`.
- The FSM and output decode live in `pipeline_run_ctrl`.

## Test plan
- Reset, RUN for 10 cycles, STOP → `o_pipe_enable` high for exactly 10 cycles; `o_cycle_count` = 10; state IDLE; RUN resumes counting from 10.
- Three STEP commands, spaced 4 cycles apart → three single-cycle `o_pipe_enable` pulses; count = 3; `o_cmd_ready` low during each STEP cycle.
- RUN, then `i_stall` high for 2 cycles → `o_pc_enable` and `o_ifid_enable` low and `o_idex_bubble` high for those 2 cycles; `o_pipe_enable` stays high; count includes both cycles.
- RUN, then `i_halt` at edge N together with a STOP command → DRAIN for exactly 3 cycles with `o_pc_enable` = 0; `o_done` high from N+4; subsequent RUN accepted with no effect; CLEAR gives a one-cycle `o_pipe_clear`, count 0, state IDLE.
- `CNT_BITS` = 4: RUN for 20 cycles → count holds at 15.
- `i_reset` asserted in the 2nd DRAIN cycle → next cycle all outputs at reset values, `o_done` never rises.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline run/step sequencer.
// Contents: the FSM state encoding, the debug command codes and the default
// drain length.
package pipeline_ctrl_pkg;

  // Debug command codes as they arrive on i_cmd.
  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  // Number of cycles needed to retire EX/MEM/WB once HALT sits in decode.
  localparam int DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that holds at all-ones instead of wrapping.
// Latency: the count reflects i_inc/i_clear one cycle after the sampling edge.
// Backpressure: none; i_clear takes priority over i_inc.
// Ports: i_clk, i_reset (sync, active-high), i_clear, i_inc, o_count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step sequencer for the five-stage pipeline: stage enables, load-use
// stall gating, HALT drain and a saturating executed-cycle counter.
// Latency: a command accepted at edge N changes the enables from cycle N+1;
// o_pipe_clear is the registered pulse in the cycle after CLEAR acceptance.
// Backpressure: o_cmd_ready is low in STEP and DRAIN, high otherwise.
// Ports: i_clk, i_reset, i_cmd_valid/i_cmd/o_cmd_ready (command handshake),
// i_halt, i_stall, o_pipe_enable, o_pc_enable, o_ifid_enable, o_idex_bubble,
// o_pipe_clear, o_busy, o_done, o_cycle_count.
module pipeline_run_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_BITS     = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_halt,
  input  logic                i_stall,
  output logic                o_pipe_enable,
  output logic                o_pc_enable,
  output logic                o_ifid_enable,
  output logic                o_idex_bubble,
  output logic                o_pipe_clear,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_BITS-1:0] o_cycle_count
);

  run_state_e state;
  run_state_e stateNext;
  logic [3:0] drainCnt;
  logic       cmdAccept;
  logic       clearGo;
  logic       stallGate;

  assign cmdAccept = i_cmd_valid && o_cmd_ready;

  // A HALT in RUN swallows whatever command arrives with it, CLEAR included.
  assign clearGo = cmdAccept && (i_cmd == CMD_CLEAR) &&
                   !((state == ST_RUN) && i_halt);

  // State register plus the drain down-counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      drainCnt     <= 4'd0;
      o_pipe_clear <= 1'b0;
    end else begin
      state        <= stateNext;
      o_pipe_clear <= clearGo;
      if (state != ST_DRAIN && stateNext == ST_DRAIN) begin
        drainCnt <= 4'(DRAIN_CYCLES - 1);
      end else if (state == ST_DRAIN && drainCnt != 4'd0) begin
        drainCnt <= drainCnt - 4'd1;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (cmdAccept && i_cmd == CMD_RUN)  stateNext = ST_RUN;
        if (cmdAccept && i_cmd == CMD_STEP) stateNext = ST_STEP;
      end
      ST_RUN: begin
        if (i_halt) begin
          stateNext = ST_DRAIN;
        end else if (cmdAccept && (i_cmd == CMD_STOP || i_cmd == CMD_CLEAR)) begin
          stateNext = ST_IDLE;
        end
      end
      ST_STEP:  stateNext = i_halt ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (drainCnt == 4'd0) stateNext = ST_DONE;
      ST_DONE:  if (cmdAccept && i_cmd == CMD_CLEAR) stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // Output decode: state plus i_stall only, no registered outputs here.
  always_comb begin
    o_pipe_enable = 1'b0;
    o_pc_enable   = 1'b0;
    o_ifid_enable = 1'b0;
    o_idex_bubble = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_cmd_ready   = 1'b0;
    stallGate     = 1'b0;
    case (state)
      ST_IDLE: o_cmd_ready = 1'b1;
      ST_RUN, ST_STEP: begin
        o_pipe_enable = 1'b1;
        o_busy        = 1'b1;
        o_cmd_ready   = (state == ST_RUN);
        stallGate     = i_stall;
        // A load-use stall freezes fetch/decode and bubbles execute, but the
        // downstream stages keep moving so the cycle still counts.
        o_pc_enable   = !stallGate;
        o_ifid_enable = !stallGate;
        o_idex_bubble = stallGate;
      end
      ST_DRAIN: begin
        o_pipe_enable = 1'b1;
        o_busy        = 1'b1;
        o_idex_bubble = 1'b1;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        o_cmd_ready = 1'b1;
      end
      default: o_cmd_ready = 1'b0;
    endcase
  end

  sat_counter #(
    .WIDTH (CNT_BITS)
  ) cycleCounter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (clearGo),
    .i_inc   (o_pipe_enable),
    .o_count (o_cycle_count)
  );

endmodule
